ddr_frame_wr_ctrl: RTL and testbench
====================================

// Module: ddr_frame_wr_ctrl
// PURPOSE
//  Frame-synchronous write-side front end for axi_ddr_top. Takes a 16-bit pixel stream (vsync/de/data),
//  aligns to frame starts, pulses wr_rst to restart the DDR write address at each frame, and drives
//  data_wren/data_wr into the write FIFO port. Checks pixels-per-frame and raises read_enable once one
//  complete frame is in DDR, so the HDMI read side starts on a full frame.
// PARAMETERS
//  PIX_W       16      pixel width; data_wr[PIX_W-1:0] carries the pixel, upper bits zero
//  FRAME_PIX   921600  expected active pixels per frame (1280x720)
//  WR_RST_CYC  4       wr_rst pulse length in clocks (1..15)
//  VS_POL      1       1: frame start = rising edge of pix_vsync; 0: falling edge
// PORTS
//  sys_clk      in   1      pixel/write clock (same clock as axi_ddr_top user_wr_clk)
//  sys_rst      in   1      asynchronous, active-high reset
//  calib_done   in   1      DDR calibration done (ui_clk domain; synchronised internally)
//  pix_vsync    in   1      frame sync
//  pix_de       in   1      pixel valid
//  pix_data     in   PIX_W  pixel
//  data_wren    out  1      write-FIFO write request
//  data_wr      out  65     write-FIFO data, {(65-PIX_W)'b0, pixel}
//  wr_rst       out  1      DDR write address reset pulse
//  read_enable  out  1      sticky: first good frame written
//  frame_cnt    out  8      completed good frames, wraps 255->0
//  frame_err    out  1      1-cycle pulse: frame closed with wrong pixel count
//  err_cnt      out  8      bad frames, saturates at 255
// BEHAVIOUR
//  Reset: all outputs 0, state S_CALIB, counters 0, sync/edge flops 0.
//  calib_done passes a 2-FF synchroniser (cal_s); sys_clk->cal_s latency 2 cycles.
//  pix_vsync registered twice (vs1, vs2), polarity per VS_POL; vs_edge = vs1 & ~vs2 (inverted if VS_POL=0).
//  States:
//   S_CALIB: wait cal_s=1 -> S_SYNC. Input pixels ignored.
//   S_SYNC : wait vs_edge -> S_RST. Discards the partial frame in progress at start-up.
//   S_RST  : wr_rst=1 for exactly WR_RST_CYC cycles, starting the cycle after vs_edge; pix_cnt cleared;
//            pix_de ignored; then -> S_WRITE.
//   S_WRITE: data_wren <= pix_de & (pix_cnt < FRAME_PIX); data_wr <= pix_data zero-extended;
//            1-cycle latency pix_de -> data_wren. pix_cnt (20 bits) +1 per accepted pixel, stops at FRAME_PIX;
//            de beyond FRAME_PIX dropped, ovf flag set.
//            On vs_edge: if pix_cnt==FRAME_PIX & !ovf -> frame_cnt+1, read_enable<=1;
//            else frame_err pulse, err_cnt+1 (sat). Clear ovf, -> S_RST.
//  Same-cycle pix_de and vs_edge in S_WRITE: the pixel is accepted (counted) before the frame check.
//  cal_s falling in any state -> S_CALIB next cycle; data_wren, wr_rst, read_enable cleared; counters held.
//  data_wren is 0 in all states except S_WRITE. data_wr holds its last value when data_wren=0.
//  wr_rst never overlaps data_wren.
//  No backpressure from the FIFO; overflow handling is the FIFO's responsibility.
// TESTING (sim with FRAME_PIX=16, WR_RST_CYC=4, VS_POL=1)
//  1. sys_rst=1 mid-S_WRITE with pix_de=1 -> all outputs 0 same cycle (async), state S_CALIB after release.
//  2. calib_done 0->1, then vsync edge -> wr_rst high exactly 4 cycles, beginning 1 cycle after vs_edge;
//     no data_wren before the first vsync.
//  3. 16 pixels 0x0001..0x0010 then vsync -> 16 data_wren pulses, data_wr=0x0001..0x0010 with 1-cycle lag;
//     frame_cnt=1, read_enable=1, frame_err=0.
//  4. Frame of 20 pixels -> only 16 data_wren pulses; frame_err pulses once, err_cnt=1, frame_cnt unchanged.
//  5. Frame of 15 pixels -> frame_err pulses, err_cnt increments; next 16-pixel frame -> frame_cnt increments.
//  6. 256 good frames -> frame_cnt wraps to 0; drop calib_done mid-frame -> data_wren=0, read_enable=0
//     within 3 cycles; restore -> resyncs on next vsync.

Source files
------------

// File: rtl/ddr_frame_wr_ctrl_if.sv
// Pixel-in / write-FIFO-out bundle for the frame write controller.
// The controller uses the slave view; the pixel source uses the master view.
interface ddr_frame_wr_ctrl_if #(
    parameter int PIX_W = 16
);
    logic             pix_vsync;
    logic             pix_de;
    logic [PIX_W-1:0] pix_data;
    logic             data_wren;
    logic [64:0]      data_wr;
    logic             wr_rst;

    modport master (
        output pix_vsync, pix_de, pix_data,
        input  data_wren, data_wr, wr_rst
    );

    modport slave (
        input  pix_vsync, pix_de, pix_data,
        output data_wren, data_wr, wr_rst
    );
endinterface

// File: rtl/ddr_frame_wr_ctrl.sv
// Frame-synchronous DDR write front end: aligns the pixel stream to frame starts,
// resets the DDR write address per frame and validates the pixel count of each frame.
module ddr_frame_wr_ctrl #(
    parameter int PIX_W      = 16,
    parameter int FRAME_PIX  = 921600,
    parameter int WR_RST_CYC = 4,
    parameter int VS_POL     = 1
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                calib_done,
    ddr_frame_wr_ctrl_if.slave  bus,
    output logic                read_enable,
    output logic [7:0]          frame_cnt,
    output logic                frame_err,
    output logic [7:0]          err_cnt
);

    typedef enum logic [1:0] {S_CALIB, S_SYNC, S_RST, S_WRITE} state_e;

    localparam logic [19:0] FRAME_LIM = 20'(FRAME_PIX);
    localparam logic [3:0]  RST_LAST  = 4'(WR_RST_CYC - 1);

    state_e      state_q, state_d;
    logic        cal1_q, cal1_d, cal_s_q, cal_s_d;
    logic        vs1_q, vs1_d, vs2_q, vs2_d;
    logic [3:0]  rst_cnt_q, rst_cnt_d;
    logic [19:0] pix_cnt_q, pix_cnt_d;
    logic        ovf_q, ovf_d;
    logic        data_wren_q, data_wren_d;
    logic [64:0] data_wr_q, data_wr_d;
    logic        read_enable_q, read_enable_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic        frame_err_q, frame_err_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    logic        vs_edge, in_write, rst_go, wr_rst;
    logic        pix_ok, acc, ovf_after, frame_end, frame_good, frame_bad;
    logic [19:0] cnt_after;

    // Frame-start polarity is folded in before the edge detector.
    assign cal1_d  = calib_done;
    assign cal_s_d = cal1_q;
    assign vs1_d   = (VS_POL != 0) ? bus.pix_vsync : ~bus.pix_vsync;
    assign vs2_d   = vs1_q;
    assign vs_edge = vs1_q & ~vs2_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) state_q <= S_CALIB;
        else         state_q <= state_d;
    end

    always_comb begin
        // NOTE: default assignment first so no path through the case can infer a latch.
        state_d = state_q;
        if (!cal_s_q) begin
            state_d = S_CALIB;
        end else begin
            case (state_q)
                S_CALIB: state_d = S_SYNC;
                S_SYNC:  if (vs_edge) state_d = S_RST;
                S_RST:   if (rst_go && rst_cnt_q == RST_LAST) state_d = S_WRITE;
                S_WRITE: if (vs_edge) state_d = S_RST;
                default: state_d = S_CALIB;
            endcase
        end
    end

    // A pixel written on the closing vs_edge cycle delays the address reset by one
    // cycle, so wr_rst never coincides with a FIFO write and still lasts WR_RST_CYC.
    always_comb begin
        in_write = cal_s_q && (state_q == S_WRITE);
        rst_go   = ~data_wren_q;
        wr_rst   = (state_q == S_RST) && rst_go;
    end

    always_comb begin
        pix_ok     = pix_cnt_q < FRAME_LIM;
        acc        = in_write & bus.pix_de & pix_ok;
        cnt_after  = pix_cnt_q + 20'(acc);
        ovf_after  = ovf_q | (in_write & bus.pix_de & ~pix_ok);
        frame_end  = in_write & vs_edge;
        frame_good = frame_end && (cnt_after == FRAME_LIM) && !ovf_after;
        frame_bad  = frame_end & ~frame_good;

        rst_cnt_d  = (state_q == S_RST) ? rst_cnt_q + 4'(rst_go) : 4'd0;
        pix_cnt_d  = (state_q == S_WRITE && !frame_end) ? cnt_after : 20'd0;
        ovf_d      = (state_q == S_WRITE && !frame_end) ? ovf_after : 1'b0;

        data_wren_d   = acc;
        data_wr_d     = acc ? {{(65-PIX_W){1'b0}}, bus.pix_data} : data_wr_q;
        read_enable_d = cal_s_q & (read_enable_q | frame_good);
        frame_cnt_d   = frame_cnt_q + 8'(frame_good);
        frame_err_d   = frame_bad;
        err_cnt_d     = (frame_bad && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cal1_q        <= 1'b0;
            cal_s_q       <= 1'b0;
            vs1_q         <= 1'b0;
            vs2_q         <= 1'b0;
            rst_cnt_q     <= '0;
            pix_cnt_q     <= '0;
            ovf_q         <= 1'b0;
            data_wren_q   <= 1'b0;
            data_wr_q     <= '0;
            read_enable_q <= 1'b0;
            frame_cnt_q   <= '0;
            frame_err_q   <= 1'b0;
            err_cnt_q     <= '0;
        end else begin
            cal1_q        <= cal1_d;
            cal_s_q       <= cal_s_d;
            vs1_q         <= vs1_d;
            vs2_q         <= vs2_d;
            rst_cnt_q     <= rst_cnt_d;
            pix_cnt_q     <= pix_cnt_d;
            ovf_q         <= ovf_d;
            data_wren_q   <= data_wren_d;
            data_wr_q     <= data_wr_d;
            read_enable_q <= read_enable_d;
            frame_cnt_q   <= frame_cnt_d;
            frame_err_q   <= frame_err_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    assign bus.data_wren = data_wren_q;
    assign bus.data_wr   = data_wr_q;
    assign bus.wr_rst    = wr_rst;
    assign read_enable   = read_enable_q;
    assign frame_cnt     = frame_cnt_q;
    assign frame_err     = frame_err_q;
    assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_ddr_frame_wr_ctrl.sv
// Directed bench for ddr_frame_wr_ctrl with 16-pixel frames and a 4-cycle address reset.
module tb_ddr_frame_wr_ctrl;

    logic       sys_clk;
    logic       sys_rst;
    logic       calib_done;
    logic       read_enable;
    logic [7:0] frame_cnt;
    logic       frame_err;
    logic [7:0] err_cnt;

    int n_checks;
    int n_fail;
    int wren_seen;
    int err_pulses;
    int overlap;
    int rst_hi;
    int wren0;
    logic [7:0] rst_pat;

    ddr_frame_wr_ctrl_if #(.PIX_W(16)) bus ();

    ddr_frame_wr_ctrl #(
        .PIX_W(16), .FRAME_PIX(16), .WR_RST_CYC(4), .VS_POL(1)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .calib_done (calib_done),
        .bus        (bus),
        .read_enable(read_enable),
        .frame_cnt  (frame_cnt),
        .frame_err  (frame_err),
        .err_cnt    (err_cnt)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, step past the rising edge, record output activity.
    task automatic cyc(input logic vs, input logic de, input logic [15:0] d);
        bus.pix_vsync = vs;
        bus.pix_de    = de;
        bus.pix_data  = d;
        @(posedge sys_clk);
        #1;
        if (bus.data_wren === 1'b1) wren_seen++;
        if (frame_err === 1'b1) err_pulses++;
        if (bus.data_wren === 1'b1 && bus.wr_rst === 1'b1) overlap++;
        if (bus.wr_rst === 1'b1) rst_hi++;
        rst_pat = {rst_pat[6:0], bus.wr_rst};
    endtask

    task automatic new_frame(input logic last_pix, input logic [15:0] d);
        rst_hi  = 0;
        rst_pat = '0;
        cyc(1'b1, 1'b0, 16'h0);
        cyc(1'b1, last_pix, d);
        repeat (last_pix ? 5 : 4) cyc(1'b0, 1'b0, 16'h0);
    endtask

    task automatic send_frame(input int n, input logic [15:0] base, input bit chk);
        logic [15:0] d;
        for (int i = 0; i < n; i++) begin
            d = base + 16'(i);
            cyc(1'b0, 1'b1, d);
            if (chk) begin
                if (i < 16) begin
                    check("pix_wren", bus.data_wren, 1'b1);
                    check("pix_data", bus.data_wr, {49'b0, d});
                end else begin
                    check("drop_wren", bus.data_wren, 1'b0);
                    check("drop_hold", bus.data_wr, {49'b0, base + 16'd15});
                end
            end
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0; wren_seen = 0; err_pulses = 0; overlap = 0; rst_hi = 0;
        rst_pat = '0;
        sys_rst = 1'b1; calib_done = 1'b0;
        bus.pix_vsync = 1'b0; bus.pix_de = 1'b0; bus.pix_data = '0;
        #1;
        check("rst_wren", bus.data_wren, 1'b0);
        check("rst_wr_rst", bus.wr_rst, 1'b0);
        check("rst_read_en", read_enable, 1'b0);
        check("rst_frame_cnt", frame_cnt, 8'd0);
        repeat (2) @(posedge sys_clk);
        #1 sys_rst = 1'b0;

        // Calibration done, pixels arrive but nothing is written before the first vsync.
        calib_done = 1'b1;
        wren0 = wren_seen; rst_hi = 0;
        repeat (6) cyc(1'b0, 1'b1, 16'hBEEF);
        check("presync_wren", wren_seen - wren0, 0);
        check("presync_wr_rst", rst_hi, 0);

        wren0 = wren_seen;
        new_frame(1'b0, 16'h0);
        check("first_rst_pattern", rst_pat, 8'b0001_1110);
        check("first_rst_len", rst_hi, 4);
        check("first_rst_wren", wren_seen - wren0, 0);

        // Good frame 0x0001..0x0010.
        wren0 = wren_seen;
        send_frame(16, 16'h0001, 1'b1);
        new_frame(1'b0, 16'h0);
        check("good_wren_cnt", wren_seen - wren0, 16);
        check("good_frame_cnt", frame_cnt, 8'd1);
        check("good_read_en", read_enable, 1'b1);
        check("good_no_err", err_pulses, 0);

        // 20-pixel frame: 4 pixels dropped, frame rejected.
        wren0 = wren_seen;
        send_frame(20, 16'h0021, 1'b1);
        new_frame(1'b0, 16'h0);
        check("long_wren_cnt", wren_seen - wren0, 16);
        check("long_err_pulse", err_pulses, 1);
        check("long_err_cnt", err_cnt, 8'd1);
        check("long_frame_cnt", frame_cnt, 8'd1);

        // 15-pixel frame rejected, following full frame accepted.
        send_frame(15, 16'h0041, 1'b1);
        new_frame(1'b0, 16'h0);
        check("short_err_pulse", err_pulses, 2);
        check("short_err_cnt", err_cnt, 8'd2);
        check("short_frame_cnt", frame_cnt, 8'd1);
        send_frame(16, 16'h0061, 1'b1);
        new_frame(1'b0, 16'h0);
        check("after_short_frame_cnt", frame_cnt, 8'd2);

        // 16th pixel arrives on the vs_edge cycle: counted, address reset deferred.
        wren0 = wren_seen;
        send_frame(15, 16'h0081, 1'b1);
        new_frame(1'b1, 16'h0090);
        check("coinc_wren_cnt", wren_seen - wren0, 16);
        check("coinc_data", bus.data_wr, 65'h0090);
        check("coinc_frame_cnt", frame_cnt, 8'd3);
        check("coinc_rst_len", rst_hi, 4);
        check("coinc_err_cnt", err_cnt, 8'd2);

        // 253 more good frames take frame_cnt from 3 through 255 to 0.
        for (int f = 0; f < 253; f++) begin
            send_frame(16, 16'(f * 16), 1'b0);
            new_frame(1'b0, 16'h0);
        end
        check("wrap_frame_cnt", frame_cnt, 8'd0);
        check("wrap_err_cnt", err_cnt, 8'd2);
        check("wrap_err_pulses", err_pulses, 2);
        check("wrap_read_en", read_enable, 1'b1);

        // Calibration lost mid-frame.
        send_frame(8, 16'h0100, 1'b1);
        calib_done = 1'b0;
        repeat (3) cyc(1'b0, 1'b1, 16'h0200);
        check("cal_drop_wren", bus.data_wren, 1'b0);
        check("cal_drop_read_en", read_enable, 1'b0);
        check("cal_drop_frame_cnt", frame_cnt, 8'd0);
        check("cal_drop_err_cnt", err_cnt, 8'd2);

        calib_done = 1'b1;
        wren0 = wren_seen; rst_hi = 0;
        repeat (6) cyc(1'b0, 1'b1, 16'h0300);
        check("recal_no_wren", wren_seen - wren0, 0);
        check("recal_no_rst", rst_hi, 0);
        new_frame(1'b0, 16'h0);
        check("recal_rst_pattern", rst_pat, 8'b0001_1110);
        send_frame(16, 16'h0400, 1'b1);
        new_frame(1'b0, 16'h0);
        check("recal_frame_cnt", frame_cnt, 8'd1);
        check("recal_read_en", read_enable, 1'b1);

        // Asynchronous reset while a pixel write is in flight.
        send_frame(5, 16'h0500, 1'b1);
        #2 sys_rst = 1'b1;
        #1;
        check("async_wren", bus.data_wren, 1'b0);
        check("async_data_wr", bus.data_wr, 65'h0);
        check("async_wr_rst", bus.wr_rst, 1'b0);
        check("async_read_en", read_enable, 1'b0);
        check("async_frame_cnt", frame_cnt, 8'd0);
        check("async_err_cnt", err_cnt, 8'd0);
        @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        wren0 = wren_seen; rst_hi = 0;
        repeat (6) cyc(1'b0, 1'b1, 16'h0600);
        check("post_rst_no_wren", wren_seen - wren0, 0);
        new_frame(1'b0, 16'h0);
        check("post_rst_pattern", rst_pat, 8'b0001_1110);
        check("no_overlap", overlap, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
